// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU types for the memory stage: word/register types, opcodes, memory FSM states.
package mem_wb_stage_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic [5:0] {
      RTYPE = 6'b000000,
      JAL   = 6'b000011,
      LW    = 6'b100011,
      SW    = 6'b101011,
      LL    = 6'b110000,
      SC    = 6'b111000
   } opcode_t;

   typedef enum logic {
      IDLE,
      WAIT
   } memstate_t;

   localparam logic [1:0] WSRC_PCP4 = 2'd1;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-cache request/response bus between the memory stage (master) and the dcache (slave).
interface mem_wb_stage_if;
   import mem_wb_stage_pkg::*;

   logic  dmemREN;
   logic  dmemWEN;
   word_t dmemaddr;
   word_t dmemstore;
   logic  dhit;
   word_t dmemload;

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload
   );

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload
   );

endinterface

// File: rtl/mem_wb_stage_link_reg.sv
// LL/SC link register: set by a completing LL, cleared by SC/store/snoop; set beats clear.
module mem_wb_stage_link_reg
   import mem_wb_stage_pkg::*;
#(
   parameter bit LINK_EN = 1'b1
) (
   input  logic  CLK,
   input  logic  nRST,
   input  logic  set,
   input  word_t set_addr,
   input  logic  clear,
   input  logic  snoop_inv,
   input  word_t snoop_addr,
   output logic  link_valid,
   output word_t link_addr
);

   word_t addr_q;
   logic  valid_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         addr_q  <= '0;
         valid_q <= 1'b0;
      end else if (set) begin
         addr_q  <= set_addr;
         valid_q <= 1'b1;
      end else if (clear || (snoop_inv && (snoop_addr == addr_q))) begin
         valid_q <= 1'b0;
      end
   end

   // With the link disabled the register never reports valid; SC then always succeeds.
   assign link_valid = LINK_EN ? valid_q : 1'b0;
   assign link_addr  = addr_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage plus M/WB pipeline register: dcache request/hold FSM, LL/SC handling,
// writeback data selection and the sticky halt.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter bit LINK_EN = 1'b1
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  dREN_in,
   input  logic                  dWEN_in,
   input  word_t                 addr_in,
   input  word_t                 store_in,
   input  logic                  MemtoReg,
   input  logic [1:0]            wdatasrc,
   input  regbits_t              WSel_in,
   input  logic                  WEN_in,
   input  word_t                 pcp4_in,
   input  logic                  HALT_in,
   input  logic [5:0]            opcode_in,
   input  logic                  flush,
   mem_wb_stage_if.master        dbus,
   input  logic                  snoop_inv,
   input  word_t                 snoop_addr,
   output logic                  mem_stall,
   output logic                  wb_WEN,
   output regbits_t              wb_WSel,
   output word_t                 wb_wdat,
   output logic                  wb_HALT
);

   memstate_t state;
   logic      req_ren_q;
   logic      req_wen_q;
   word_t     req_addr_q;
   word_t     req_store_q;

   logic      req_ren;
   logic      req_wen;
   word_t     req_addr;
   word_t     req_store;

   logic      is_ll;
   logic      is_sc;
   logic      sc_ok;
   logic      sc_fail;
   logic      memop;
   logic      done;
   logic      ll_done;
   logic      sw_hit_link;
   logic      link_clear;
   logic      link_valid;
   word_t     link_addr;
   word_t     wdat_sel;

   assign is_ll   = dREN_in && (opcode_in == LL);
   assign is_sc   = dWEN_in && (opcode_in == SC);
   assign sc_ok   = !LINK_EN || (link_valid && (link_addr == addr_in));
   // Once an SC has issued its outcome is fixed; only an IDLE evaluation can fail it.
   assign sc_fail = is_sc && !sc_ok && (state == IDLE);

   always_comb begin
      if (state == WAIT) begin
         req_ren   = req_ren_q;
         req_wen   = req_wen_q;
         req_addr  = req_addr_q;
         req_store = req_store_q;
      end else begin
         req_ren   = dREN_in && !sc_fail && !wb_HALT;
         req_wen   = dWEN_in && !sc_fail && !wb_HALT;
         req_addr  = addr_in;
         req_store = store_in;
      end
   end

   // nRST gating drops a pending request the moment reset asserts.
   assign memop          = (req_ren || req_wen) && nRST;
   assign mem_stall      = memop && !dbus.dhit;
   assign done           = memop && dbus.dhit;
   assign dbus.dmemREN   = req_ren && nRST;
   assign dbus.dmemWEN   = req_wen && nRST;
   assign dbus.dmemaddr  = req_addr;
   assign dbus.dmemstore = req_store;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= IDLE;
         req_ren_q   <= 1'b0;
         req_wen_q   <= 1'b0;
         req_addr_q  <= '0;
         req_store_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_stall) begin
                  state       <= WAIT;
                  req_ren_q   <= req_ren;
                  req_wen_q   <= req_wen;
                  req_addr_q  <= req_addr;
                  req_store_q <= req_store;
               end
            end
            WAIT: begin
               if (dbus.dhit) begin
                  state     <= IDLE;
                  req_ren_q <= 1'b0;
                  req_wen_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign ll_done     = done && req_ren && is_ll;
   assign sw_hit_link = done && req_wen && (req_addr == link_addr);
   assign link_clear  = (is_sc && (sc_fail || done)) || sw_hit_link;

   mem_wb_stage_link_reg #(
      .LINK_EN (LINK_EN)
   ) u_link_reg (
      .CLK        (CLK),
      .nRST       (nRST),
      .set        (ll_done),
      .set_addr   (req_addr),
      .clear      (link_clear),
      .snoop_inv  (snoop_inv),
      .snoop_addr (snoop_addr),
      .link_valid (link_valid),
      .link_addr  (link_addr)
   );

   always_comb begin
      wdat_sel = addr_in;
      if (is_sc) begin
         wdat_sel = {31'b0, (state == WAIT) || sc_ok};
      end else if (MemtoReg) begin
         wdat_sel = dbus.dmemload;
      end else if (wdatasrc == WSRC_PCP4) begin
         wdat_sel = pcp4_in;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wb_WEN  <= 1'b0;
         wb_WSel <= '0;
         wb_wdat <= '0;
         wb_HALT <= 1'b0;
      end else if (!mem_stall) begin
         if (flush) begin
            wb_WEN  <= 1'b0;
            wb_WSel <= '0;
            wb_wdat <= '0;
         end else begin
            wb_WEN  <= WEN_in && !wb_HALT;
            wb_WSel <= WSel_in;
            wb_wdat <= wdat_sel;
            wb_HALT <= wb_HALT || HALT_in;
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: vector table, directed multi-cycle cases, random instruction stream.
module tb_mem_wb_stage;
   import mem_wb_stage_pkg::*;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       dREN_in, dWEN_in, MemtoReg, WEN_in, HALT_in, flush, snoop_inv;
   word_t      addr_in, store_in, pcp4_in, snoop_addr;
   logic [1:0] wdatasrc;
   regbits_t   WSel_in;
   logic [5:0] opcode_in;
   logic       mem_stall, wb_WEN, wb_HALT;
   regbits_t   wb_WSel;
   word_t      wb_wdat;

   int total = 0;
   int bad   = 0;

   logic  m_valid;
   word_t m_addr;

   mem_wb_stage_if dbus ();

   mem_wb_stage #(
      .LINK_EN (1'b1)
   ) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .dREN_in    (dREN_in),
      .dWEN_in    (dWEN_in),
      .addr_in    (addr_in),
      .store_in   (store_in),
      .MemtoReg   (MemtoReg),
      .wdatasrc   (wdatasrc),
      .WSel_in    (WSel_in),
      .WEN_in     (WEN_in),
      .pcp4_in    (pcp4_in),
      .HALT_in    (HALT_in),
      .opcode_in  (opcode_in),
      .flush      (flush),
      .dbus       (dbus),
      .snoop_inv  (snoop_inv),
      .snoop_addr (snoop_addr),
      .mem_stall  (mem_stall),
      .wb_WEN     (wb_WEN),
      .wb_WSel    (wb_WSel),
      .wb_wdat    (wb_wdat),
      .wb_HALT    (wb_HALT)
   );

   always #5 CLK = ~CLK;

   // Instruction kinds: 0 ALU, 1 JAL, 2 LW, 3 SW, 4 LL, 5 SC.
   typedef struct {
      int         k;
      word_t      a, st, pc, ld;
      logic [1:0] src;
      logic [4:0] ws, xws;
      logic       we, fl, hit, xr, xw, xs, xwe;
      word_t      xd;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input int k, input word_t a, input word_t st, input word_t pc,
                        input logic [1:0] src, input logic [4:0] ws, input logic we,
                        input logic fl, input word_t ld);
      dREN_in       = (k == 2) || (k == 4);
      dWEN_in       = (k == 3) || (k == 5);
      MemtoReg      = (k == 2) || (k == 4);
      addr_in       = a;
      store_in      = st;
      pcp4_in       = pc;
      wdatasrc      = (k == 1) ? 2'd1 : src;
      WSel_in       = ws;
      WEN_in        = we;
      flush         = fl;
      HALT_in       = 1'b0;
      dbus.dmemload = ld;
      case (k)
         1:       opcode_in = JAL;
         2:       opcode_in = LW;
         3:       opcode_in = SW;
         4:       opcode_in = LL;
         5:       opcode_in = SC;
         default: opcode_in = RTYPE;
      endcase
   endtask

   task automatic idle();
      drive(0, 32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0);
      dbus.dhit  = 1'b0;
      snoop_inv  = 1'b0;
      snoop_addr = 32'h0;
   endtask

   function automatic vec_t mk(input int k, input word_t a, input word_t st, input word_t pc,
                               input logic [1:0] src, input logic [4:0] ws, input logic we,
                               input logic fl, input logic hit, input word_t ld,
                               input logic xr, input logic xw, input logic xs,
                               input logic xwe, input logic [4:0] xws, input word_t xd);
      vec_t v;
      v.k = k;  v.a = a;  v.st = st;  v.pc = pc;  v.src = src;  v.ws = ws;  v.we = we;
      v.fl = fl;  v.hit = hit;  v.ld = ld;  v.xr = xr;  v.xw = xw;  v.xs = xs;
      v.xwe = xwe;  v.xws = xws;  v.xd = xd;
      return v;
   endfunction

   // One instruction through the stage, completing in one cycle.
   task automatic one_cycle(input int k, input word_t a, input word_t st, input word_t pc,
                            input logic we, input logic hit, input word_t ld);
      drive(k, a, st, pc, 2'd0, 5'd2, we, 1'b0, ld);
      dbus.dhit = hit;
      @(posedge CLK);
      #1;
      dbus.dhit = 1'b0;
   endtask

   // Random stream checked against an instruction-level model of the link register.
   task automatic run_random(input int n_instr);
      int         k, lat;
      word_t      a, st, pc, ld, sa, x_wdat;
      logic [1:0] src;
      logic [4:0] ws, x_wsel;
      logic       we, fl, sn, sc_ok, issue, x_ren, x_wen, x_wbwen;
      word_t      pool [4];
      logic [1:0] srcs [3];
      pool = '{32'h40, 32'h80, 32'hC0, 32'h100};
      srcs = '{2'd0, 2'd2, 2'd3};
      for (int n = 0; n < n_instr; n++) begin
         k   = int'($urandom_range(0, 5));
         a   = (k < 2) ? word_t'($urandom) : pool[$urandom_range(0, 3)];
         st  = $urandom;
         pc  = $urandom;
         ld  = $urandom;
         ws  = 5'($urandom);
         we  = 1'($urandom);
         src = (k == 0) ? srcs[$urandom_range(0, 2)] : 2'd0;
         fl  = (k < 2) && ($urandom_range(0, 3) == 0);
         lat = int'($urandom_range(0, 3));
         sn  = ($urandom_range(0, 3) == 0);
         sa  = pool[$urandom_range(0, 3)];

         sc_ok = m_valid && (m_addr == a);
         issue = (k >= 2) && !((k == 5) && !sc_ok);
         x_ren = issue && ((k == 2) || (k == 4));
         x_wen = issue && ((k == 3) || (k == 5));
         if (!issue) lat = 0;
         case (k)
            5:       x_wdat = {31'b0, sc_ok};
            2, 4:    x_wdat = ld;
            1:       x_wdat = pc;
            default: x_wdat = a;
         endcase
         x_wbwen = we && !fl;
         x_wsel  = fl ? 5'd0 : ws;
         if (fl) x_wdat = 32'h0;

         // Snoop lands before completion unless a same-cycle LL completes, which wins.
         if (sn && (sa == m_addr) && !((k == 4) && (lat == 0))) m_valid = 1'b0;
         if ((k == 4) && issue) begin
            m_addr  = a;
            m_valid = 1'b1;
         end
         if (k == 5) m_valid = 1'b0;
         if ((k == 3) && (a == m_addr)) m_valid = 1'b0;

         drive(k, a, st, pc, src, ws, we, fl, ld);
         snoop_inv  = sn;
         snoop_addr = sa;
         dbus.dhit  = (lat == 0);
         for (int c = 0; c < lat; c++) begin
            @(negedge CLK);
            check($sformatf("rnd%0d stall", n), {31'b0, mem_stall}, 32'd1);
            check($sformatf("rnd%0d req", n), {30'b0, dbus.dmemREN, dbus.dmemWEN},
                  {30'b0, x_ren, x_wen});
            check($sformatf("rnd%0d addr", n), dbus.dmemaddr, a);
            @(posedge CLK);
            #1;
            snoop_inv = 1'b0;
            if (c == lat - 1) dbus.dhit = 1'b1;
         end
         @(negedge CLK);
         check($sformatf("rnd%0d nostall", n), {31'b0, mem_stall}, 32'd0);
         check($sformatf("rnd%0d req_end", n), {30'b0, dbus.dmemREN, dbus.dmemWEN},
               {30'b0, x_ren, x_wen});
         @(posedge CLK);
         #1;
         snoop_inv = 1'b0;
         dbus.dhit = 1'b0;
         check($sformatf("rnd%0d wdat", n), wb_wdat, x_wdat);
         check($sformatf("rnd%0d wen", n), {31'b0, wb_WEN}, {31'b0, x_wbwen});
         check($sformatf("rnd%0d wsel", n), {27'b0, wb_WSel}, {27'b0, x_wsel});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: run did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = mk(0, 32'h1234, 32'h0,  32'h0,  2'd0, 5'd3,  1'b1, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  32'h1234);
      vecs[1] = mk(1, 32'h99,   32'h0,  32'h44, 2'd0, 5'd31, 1'b1, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 32'h44);
      vecs[2] = mk(0, 32'hABCD, 32'h0,  32'h8,  2'd2, 5'd5,  1'b1, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  32'hABCD);
      vecs[3] = mk(2, 32'h100,  32'h0,  32'h0,  2'd0, 5'd8,  1'b1, 1'b0, 1'b1, 32'hDEAD,
                   1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  32'hDEAD);
      vecs[4] = mk(1, 32'h10,   32'h0,  32'h44, 2'd0, 5'd31, 1'b1, 1'b1, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
      vecs[5] = mk(3, 32'h200,  32'h55, 32'h0,  2'd0, 5'd0,  1'b0, 1'b0, 1'b1, 32'h0,
                   1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h200);
      vecs[6] = mk(0, 32'h7,    32'h0,  32'h20, 2'd3, 5'd1,  1'b1, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  32'h7);

      nRST = 1'b0;
      idle();
      #12;
      check("rst wb_WEN", {31'b0, wb_WEN}, 32'd0);
      check("rst wb_WSel", {27'b0, wb_WSel}, 32'd0);
      check("rst wb_wdat", wb_wdat, 32'd0);
      check("rst wb_HALT", {31'b0, wb_HALT}, 32'd0);
      check("rst mem_stall", {31'b0, mem_stall}, 32'd0);
      check("rst req", {30'b0, dbus.dmemREN, dbus.dmemWEN}, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;

      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].k, vecs[i].a, vecs[i].st, vecs[i].pc, vecs[i].src, vecs[i].ws,
               vecs[i].we, vecs[i].fl, vecs[i].ld);
         dbus.dhit = vecs[i].hit;
         @(negedge CLK);
         check($sformatf("vec%0d ren", i), {31'b0, dbus.dmemREN}, {31'b0, vecs[i].xr});
         check($sformatf("vec%0d wen", i), {31'b0, dbus.dmemWEN}, {31'b0, vecs[i].xw});
         check($sformatf("vec%0d stall", i), {31'b0, mem_stall}, {31'b0, vecs[i].xs});
         @(posedge CLK);
         #1;
         dbus.dhit = 1'b0;
         check($sformatf("vec%0d wb_WEN", i), {31'b0, wb_WEN}, {31'b0, vecs[i].xwe});
         check($sformatf("vec%0d wb_WSel", i), {27'b0, wb_WSel}, {27'b0, vecs[i].xws});
         check($sformatf("vec%0d wb_wdat", i), wb_wdat, vecs[i].xd);
      end

      // SW 0x200 with dhit after three cycles of stall.
      drive(3, 32'h200, 32'hCAFE, 32'h0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0);
      dbus.dhit = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         check("sw stall", {31'b0, mem_stall}, 32'd1);
         check("sw dmemWEN", {31'b0, dbus.dmemWEN}, 32'd1);
         check("sw dmemaddr", dbus.dmemaddr, 32'h200);
         check("sw dmemstore", dbus.dmemstore, 32'hCAFE);
         @(posedge CLK);
         #1;
      end
      dbus.dhit = 1'b1;
      @(negedge CLK);
      check("sw hit nostall", {31'b0, mem_stall}, 32'd0);
      @(posedge CLK);
      #1;
      dbus.dhit = 1'b0;

      // LL 0x40, SC 0x40 succeeds, repeated SC fails without a request.
      one_cycle(4, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1111);
      drive(5, 32'h40, 32'h7, 32'h0, 2'd0, 5'd2, 1'b1, 1'b0, 32'h0);
      dbus.dhit = 1'b1;
      @(negedge CLK);
      check("sc1 dmemWEN", {31'b0, dbus.dmemWEN}, 32'd1);
      check("sc1 store", dbus.dmemstore, 32'h7);
      @(posedge CLK);
      #1;
      check("sc1 wdat", wb_wdat, 32'd1);
      dbus.dhit = 1'b0;
      @(negedge CLK);
      check("sc2 dmemWEN", {31'b0, dbus.dmemWEN}, 32'd0);
      check("sc2 stall", {31'b0, mem_stall}, 32'd0);
      @(posedge CLK);
      #1;
      check("sc2 wdat", wb_wdat, 32'd0);

      // LL 0x40, snoop invalidate 0x40, SC 0x40 fails.
      one_cycle(4, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1, 32'h2222);
      idle();
      snoop_inv  = 1'b1;
      snoop_addr = 32'h40;
      @(posedge CLK);
      #1;
      snoop_inv = 1'b0;
      drive(5, 32'h40, 32'h7, 32'h0, 2'd0, 5'd2, 1'b1, 1'b0, 32'h0);
      dbus.dhit = 1'b1;
      @(negedge CLK);
      check("snoop sc dmemWEN", {31'b0, dbus.dmemWEN}, 32'd0);
      @(posedge CLK);
      #1;
      dbus.dhit = 1'b0;
      check("snoop sc wdat", wb_wdat, 32'd0);

      // Reset asserted while waiting on a load.
      drive(2, 32'h300, 32'h0, 32'h0, 2'd0, 5'd4, 1'b1, 1'b0, 32'h0);
      @(negedge CLK);
      check("wait dmemREN", {31'b0, dbus.dmemREN}, 32'd1);
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      nRST = 1'b0;
      #1;
      check("async rst dmemREN", {31'b0, dbus.dmemREN}, 32'd0);
      check("async rst stall", {31'b0, mem_stall}, 32'd0);
      idle();
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
      m_valid = 1'b0;
      m_addr  = 32'h0;

      run_random(60);

      // HALT is sticky and suppresses later requests and writes.
      idle();
      HALT_in = 1'b1;
      @(posedge CLK);
      #1;
      check("halt set", {31'b0, wb_HALT}, 32'd1);
      drive(2, 32'h100, 32'h0, 32'h0, 2'd0, 5'd6, 1'b1, 1'b0, 32'hBEEF);
      @(negedge CLK);
      check("halt dmemREN", {31'b0, dbus.dmemREN}, 32'd0);
      check("halt stall", {31'b0, mem_stall}, 32'd0);
      @(posedge CLK);
      #1;
      check("halt wb_WEN", {31'b0, wb_WEN}, 32'd0);
      check("halt held", {31'b0, wb_HALT}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
